writeback_unit: RTL

//  Sole driver of the register-file write port (write_enable/rd/result). Merges

---
 rtl/writeback_unit_pkg.sv | 16 +
 rtl/writeback_unit_load_rd_fifo.sv | 57 +++++
 rtl/writeback_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: datapath widths and the
// arbiter source encoding.
package writeback_unit_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_LOAD = 2'd1,
    WB_SRC_SKID = 2'd2,
    WB_SRC_ALU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/writeback_unit_load_rd_fifo.sv
// FIFO of destination register indices for outstanding loads.
// The head is read combinationally so a response retires in the same cycle.
module load_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port owner: arbitrates load responses, a one-entry ALU
// skid buffer and fresh ALU results, and tracks pending loads per register.
module writeback_unit #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            load_issue,
  output logic            load_ready,
  input  logic [4:0]      load_rd,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic            write_enable,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] result
);

  import writeback_unit_pkg::*;

  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic                 lq_full, lq_empty;
  logic [REG_IDX_W-1:0] lq_head;
  logic                 lq_push, lq_pop, alu_fire;
  logic [NUM_REGS-1:0]  pending;

  logic                 skid_valid_q, skid_valid_d;
  logic [REG_IDX_W-1:0] skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]      skid_data_q, skid_data_d;

  logic                 write_enable_q, write_enable_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      result_q, result_d;

  wb_src_e              src;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_data;

  assign load_ready = !lq_full;
  assign alu_ready  = !skid_valid_q;
  assign lq_push    = load_issue && load_ready;
  assign lq_pop     = mem_resp_valid && !lq_empty;
  assign alu_fire   = alu_valid && alu_ready;

  load_rd_fifo #(
    .DEPTH (LQ_DEPTH),
    .W     (REG_IDX_W)
  ) u_lq (
    .clock     (clock),
    .reset     (reset),
    .push      (lq_push),
    .push_data (load_rd),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // Per-register count of queued loads; x0 is never tracked.
  assign pending[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             inc, dec;
      assign inc = lq_push && (load_rd == REG_IDX_W'(gi));
      assign dec = lq_pop && (lq_head == REG_IDX_W'(gi));
      always_comb cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
      always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
      assign pending[gi] = (cnt_q != '0);
    end
  endgenerate

  assign hazard = pending[rs1] || pending[rs2];

  always_comb begin
    src      = WB_SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (lq_pop) begin
      src      = WB_SRC_LOAD;
      sel_rd   = lq_head;
      sel_data = mem_resp_data;
    end else if (skid_valid_q) begin
      src      = WB_SRC_SKID;
      sel_rd   = skid_rd_q;
      sel_data = skid_data_q;
    end else if (alu_fire) begin
      src      = WB_SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_result;
    end

    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (src == WB_SRC_SKID) skid_valid_d = 1'b0;
    // An accepted ALU result that lost arbitration parks in the skid.
    if (alu_fire && src != WB_SRC_ALU) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = alu_rd;
      skid_data_d  = alu_result;
    end

    write_enable_d = (src != WB_SRC_NONE) && (sel_rd != '0);
    rd_d           = write_enable_d ? sel_rd : rd_q;
    result_d       = write_enable_d ? sel_data : result_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid_q   <= 1'b0;
      skid_rd_q      <= '0;
      skid_data_q    <= '0;
      write_enable_q <= 1'b0;
      rd_q           <= '0;
      result_q       <= '0;
    end else begin
      skid_valid_q   <= skid_valid_d;
      skid_rd_q      <= skid_rd_d;
      skid_data_q    <= skid_data_d;
      write_enable_q <= write_enable_d;
      rd_q           <= rd_d;
      result_q       <= result_d;
    end
  end

  assign write_enable = write_enable_q;
  assign rd           = rd_q;
  assign result       = result_q;

endmodule
